// File: rtl/snake_pkg.sv
// Shared constants and types for the pacing block and its BCD score counter.
package snake_pkg;

  localparam int LEVEL_W      = 4;
  localparam int SCORE_DIGITS = 3;

  typedef enum logic {RUN, HOLD} pace_state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic bcd_digit_t bcd_inc(bcd_digit_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/pace_gen_if.sv
// Game-side bundle: status from the game into the pacer, pacing/score back out.
interface pace_gen_if;

  logic                                  i_restart;
  logic                                  i_eat;
  logic                                  i_failure;
  logic                                  i_success;
  logic                                  o_phase;
  logic [snake_pkg::LEVEL_W-1:0]         o_level;
  logic [4*snake_pkg::SCORE_DIGITS-1:0]  o_score;
  logic                                  o_running;

  modport master (
    output i_restart, i_eat, i_failure, i_success,
    input  o_phase, o_level, o_score, o_running
  );

  modport slave (
    input  i_restart, i_eat, i_failure, i_success,
    output o_phase, o_level, o_score, o_running
  );

endinterface

// File: rtl/pace_gen_bcd_counter.sv
// Multi-digit BCD incrementer with ripple carry; holds at all-nines.
module bcd_counter
  import snake_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_inc,
  output logic [4*SCORE_DIGITS-1:0]   o_value
);

  logic [4*SCORE_DIGITS-1:0] r_value;
  logic [4*SCORE_DIGITS-1:0] w_value_next;
  logic [SCORE_DIGITS-1:0]   w_nine;
  logic                      w_carry;

  for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_nine
    assign w_nine[gi] = (r_value[gi*4 +: 4] == 4'd9);
  end

  // Carry ripples ones -> tens -> hundreds; no increment once every digit is 9.
  always_comb begin
    w_value_next = r_value;
    w_carry      = i_inc && !(&w_nine);
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (w_carry) begin
        w_value_next[d*4 +: 4] = bcd_inc(r_value[d*4 +: 4]);
      end
      w_carry = w_carry && w_nine[d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= '0;
    end else begin
      r_value <= w_value_next;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/pace_gen.sv
// Game tick pacer: prescaled phase toggle whose period shrinks with level,
// frozen once the game ends, plus saturating BCD apple score.
module pace_gen
  import snake_pkg::*;
#(
  parameter int PRESCALE         = 65536,
  parameter int BASE_UNITS       = 96,
  parameter int STEP_UNITS       = 6,
  parameter int MAX_LEVEL        = 12,
  parameter int APPLES_PER_LEVEL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pace_gen_if.slave   bus
);

  localparam int UNIT_W  = $clog2(PRESCALE);
  localparam int PER_W   = $clog2(BASE_UNITS + 1);
  localparam int APPLE_W = $clog2(APPLES_PER_LEVEL + 1);

  if (BASE_UNITS <= MAX_LEVEL * STEP_UNITS) begin : g_bad_period
    $error("pace_gen: BASE_UNITS must exceed MAX_LEVEL*STEP_UNITS");
  end
  if (MAX_LEVEL > (1 << LEVEL_W) - 1) begin : g_bad_level
    $error("pace_gen: MAX_LEVEL does not fit in the level output");
  end

  pace_state_t           r_state;
  pace_state_t           w_state_next;
  logic [UNIT_W-1:0]     r_unit;
  logic [PER_W-1:0]      r_period;
  logic [PER_W-1:0]      w_reload;
  logic                  r_phase;
  logic [LEVEL_W-1:0]    r_level;
  logic [APPLE_W-1:0]    r_apple;
  logic                  w_rst;
  logic                  w_run;
  logic                  w_strobe;
  logic                  w_eat;

  assign w_rst    = !rst_n || bus.i_restart;
  assign w_run    = (r_state == RUN);
  assign w_strobe = w_run && (r_unit == UNIT_W'(PRESCALE - 1));
  assign w_eat    = w_run && bus.i_eat;
  assign w_reload = PER_W'(BASE_UNITS - int'(r_level) * STEP_UNITS);

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (bus.i_failure || bus.i_success) w_state_next = HOLD;
      HOLD:    w_state_next = HOLD;
      default: w_state_next = RUN;
    endcase
  end

  // The reload uses the level registered this cycle, so an eat landing on
  // the same strobe only affects the following period.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_unit   <= '0;
      r_period <= PER_W'(BASE_UNITS);
      r_phase  <= 1'b0;
    end else if (w_run) begin
      r_unit <= w_strobe ? '0 : r_unit + UNIT_W'(1);
      if (w_strobe) begin
        if (r_period == PER_W'(1)) begin
          r_phase  <= ~r_phase;
          r_period <= w_reload;
        end else begin
          r_period <= r_period - PER_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_level <= '0;
      r_apple <= '0;
    end else if (w_eat) begin
      if (r_apple == APPLE_W'(APPLES_PER_LEVEL - 1)) begin
        r_apple <= '0;
        if (r_level < LEVEL_W'(MAX_LEVEL)) r_level <= r_level + LEVEL_W'(1);
      end else begin
        r_apple <= r_apple + APPLE_W'(1);
      end
    end
  end

  bcd_counter u_score (
    .clk     (clk),
    .rst_n   (!w_rst),
    .i_inc   (w_eat),
    .o_value (bus.o_score)
  );

  assign bus.o_phase   = r_phase;
  assign bus.o_level   = r_level;
  assign bus.o_running = w_run;

endmodule
